sad_window_accumulator: RTL and testbench
=========================================

Name: sad_window_accumulator

Overview:
- Downstream consumer of the SAD memory address mux; owns that mux's select line.
- Alternately requests a frame pixel (Sel=0, base+inA path) and a window pixel (Sel=1, base+inB path), and takes each returned data word.
- Accumulates |frame − window| over one block of PIXELS pairs per candidate position.
- Across NumCandidates positions, tracks the minimum SAD and its candidate index for the processor's SAD search.

Parameters:
- PIXELS, 16: pixel pairs per candidate block; legal range 1..65535.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle request to begin a search; sampled only in IDLE.
- NumCandidates  input  16  number of candidate positions; latched on the accepted Start.
- DataValid  input  1  DataIn holds the word requested by the current Sel.
- DataIn  input  32  returned memory word, signed two's-complement pixel.
- Sel  output  1  mux select: 0 = frame fetch, 1 = window fetch.
- PixelIdx  output  16  current pixel index within the block, 0..PIXELS−1; used upstream to form offsets.
- CandIdx  output  16  current candidate index.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when a search completes.
- MinSad  output  32  best (smallest) SAD found; valid from Done onward.
- MinIndex  output  16  candidate index of MinSad.

Behaviour:
- Reset: state=IDLE, Sel=0, PixelIdx=0, CandIdx=0, Busy=0, Done=0, MinSad=32'hFFFFFFFF, MinIndex=0, internal accumulator=0, latched frame word=0.
- Reset asserted mid-search aborts the search immediately; no Done is issued.
- IDLE:
  - Start=1 latches NumCandidates, clears accumulator, PixelIdx and CandIdx, sets MinSad=FFFFFFFF and MinIndex=0.
  - If NumCandidates=0: go to DONE. Otherwise go to FETCH_F.
  - DataValid is ignored in IDLE.
- FETCH_F (Sel=0): wait for DataValid. On DataValid, latch DataIn as frame word and go to FETCH_W.
- FETCH_W (Sel=1): wait for DataValid. On DataValid:
  - diff = |frame − DataIn|, computed in 33-bit signed and taken as unsigned.
  - acc = acc + diff, saturating at 32'hFFFFFFFF.
  - If PixelIdx = PIXELS−1: go to COMPARE. Otherwise increment PixelIdx and go to FETCH_F.
- COMPARE: one cycle; DataValid is ignored.
  - If acc < MinSad (strict): MinSad=acc and MinIndex=CandIdx. Ties keep the earlier candidate.
  - Clear acc and PixelIdx.
  - If CandIdx = NumCandidates−1: go to DONE. Otherwise increment CandIdx and go to FETCH_F.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
  - MinSad and MinIndex hold their values until the next accepted Start or Reset.
- Start is ignored while Busy=1.
- Sel changes only on state transitions. It is registered (not combinational), so the mux output is stable for the whole wait.
- Minimum latency per candidate: 2·PIXELS+1 cycles.
- Minimum search latency with DataValid held high: 1 (accept Start) + N·(2·PIXELS+1) cycles before Done; Done rises on the next edge.
- The saturated accumulator takes part in the comparison normally: FFFFFFFF never replaces the initial FFFFFFFF.

Test Plan:
- PIXELS=4, NumCandidates=2, DataValid tied high:
  - candidate 0 pairs (10,7),(−5,5),(0,0),(100,90) → acc=23; candidate 1 all pairs equal → acc=0.
  - Required: MinSad=0, MinIndex=1, Done one cycle, exactly 1+2·9 cycles after Start.
  - Sel sequence 0,1,0,1,… with PixelIdx stepping 0..3.
- Tie: three candidates each with SAD=50 → MinSad=50, MinIndex=0.
- Stalls: DataValid asserted only every 3rd cycle → same results as the first scenario.
  - Sel and PixelIdx hold while waiting.
  - Words presented in COMPARE are ignored.
- NumCandidates=0 → Done pulses on the cycle after Start; MinSad=FFFFFFFF, MinIndex=0; Busy high for 1 cycle.
- Saturation: PIXELS=2, pairs (32'h7FFFFFFF, 32'h80000000) twice → acc=FFFFFFFF, MinSad stays FFFFFFFF, MinIndex=0.
- Reset asserted during FETCH_W of candidate 1 → next cycle all outputs at reset values, no Done.
  - A new Start then runs a full search with correct results.
  - A Start pulsed while Busy is ignored, with no restart.

Source files
------------

// File: rtl/sad_window_accumulator.sv
// SAD search engine: fetches frame/window pixel pairs via the address mux
// select, accumulates |frame - window| per candidate, and keeps the minimum.
module sad_window_accumulator #(
  parameter int unsigned PIXELS = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] NumCandidates,
  input  logic        DataValid,
  input  logic [31:0] DataIn,
  output logic        Sel,
  output logic [15:0] PixelIdx,
  output logic [15:0] CandIdx,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] MinSad,
  output logic [15:0] MinIndex
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_F,
    FETCH_W,
    COMPARE,
    DONE
  } state_t;

  localparam logic [15:0] LAST_PIX = 16'(PIXELS - 1);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] cand_q, cand_d;
  logic [15:0] num_q, num_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] min_q, min_d;
  logic [15:0] minidx_q, minidx_d;

  logic signed [32:0] sub;
  logic [31:0]        diff;
  logic [32:0]        sum;
  logic [31:0]        acc_sat;

  // 33-bit difference cannot overflow; its magnitude always fits 32 bits.
  always_comb begin
    sub = $signed({frame_q[31], frame_q})
        - $signed({DataIn[31], DataIn});
    diff = sub[32] ? 32'(-sub) : 32'(sub);
    sum = {1'b0, acc_q} + {1'b0, diff};
    acc_sat = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    cand_d   = cand_q;
    num_d    = num_q;
    acc_d    = acc_q;
    frame_d  = frame_q;
    min_d    = min_q;
    minidx_d = minidx_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          num_d    = NumCandidates;
          acc_d    = '0;
          pix_d    = '0;
          cand_d   = '0;
          min_d    = 32'hFFFF_FFFF;
          minidx_d = '0;
          state_d  = (NumCandidates == 16'd0)
                   ? DONE : FETCH_F;
        end
      end
      FETCH_F: begin
        if (DataValid) begin
          frame_d = DataIn;
          state_d = FETCH_W;
        end
      end
      FETCH_W: begin
        if (DataValid) begin
          acc_d = acc_sat;
          if (pix_q == LAST_PIX) begin
            state_d = COMPARE;
          end else begin
            pix_d   = pix_q + 16'd1;
            state_d = FETCH_F;
          end
        end
      end
      COMPARE: begin
        if (acc_q < min_q) begin
          min_d    = acc_q;
          minidx_d = cand_q;
        end
        acc_d = '0;
        pix_d = '0;
        if (cand_q == num_q - 16'd1) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + 16'd1;
          state_d = FETCH_F;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sel_d = (state_d == FETCH_W);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      pix_q    <= '0;
      cand_q   <= '0;
      num_q    <= '0;
      acc_q    <= '0;
      frame_q  <= '0;
      min_q    <= 32'hFFFF_FFFF;
      minidx_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pix_q    <= pix_d;
      cand_q   <= cand_d;
      num_q    <= num_d;
      acc_q    <= acc_d;
      frame_q  <= frame_d;
      min_q    <= min_d;
      minidx_q <= minidx_d;
    end
  end

  assign Sel      = sel_q;
  assign PixelIdx = pix_q;
  assign CandIdx  = cand_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign MinSad   = min_q;
  assign MinIndex = minidx_q;

endmodule

// File: tb/tb_sad_window_accumulator.sv
// Scoreboard bench: stimulus queues expected search results, monitors
// compare them when Done is seen. Bench acts as the pixel memory.
module tb_sad_window_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        st4, st2;
  logic [15:0] nc4, nc2;
  logic        dv4;
  logic [31:0] din4, din2;
  logic        sel4, sel2;
  logic [15:0] pix4, pix2, cand4, cand2;
  logic        busy4, busy2, done4, done2;
  logic [31:0] ms4, ms2;
  logic [15:0] mi4, mi2;

  logic [31:0] frm [4][4];
  logic [31:0] win [4][4];

  typedef struct {
    logic [31:0] sad;
    logic [15:0] idx;
    int          lat;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   errs = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  bit   pd4 = 1'b0;
  bit   pd2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  sad_window_accumulator #(.PIXELS(4)) u4 (
    .Clk(clk), .Reset(rst), .Start(st4),
    .NumCandidates(nc4), .DataValid(dv4), .DataIn(din4),
    .Sel(sel4), .PixelIdx(pix4), .CandIdx(cand4),
    .Busy(busy4), .Done(done4), .MinSad(ms4), .MinIndex(mi4)
  );

  sad_window_accumulator #(.PIXELS(2)) u2 (
    .Clk(clk), .Reset(rst), .Start(st2),
    .NumCandidates(nc2), .DataValid(1'b1), .DataIn(din2),
    .Sel(sel2), .PixelIdx(pix2), .CandIdx(cand2),
    .Busy(busy2), .Done(done2), .MinSad(ms2), .MinIndex(mi2)
  );

  always_comb begin
    din4 = sel4 ? win[cand4[1:0]][pix4[1:0]]
                : frm[cand4[1:0]][pix4[1:0]];
    din2 = sel2 ? win[cand2[1:0]][pix2[1:0]]
                : frm[cand2[1:0]][pix2[1:0]];
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pd4) chk("done_pulse4", {31'b0, done4}, 32'd0);
    if (pd2) chk("done_pulse2", {31'b0, done2}, 32'd0);
    if (done4 && !pd4) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("minsad4", ms4, e.sad);
        chk("minidx4", {16'b0, mi4}, {16'b0, e.idx});
        if (e.lat >= 0) chk("latency4", 32'(edge_cnt), 32'(e.lat));
      end
    end
    if (done2 && !pd2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("minsad2", ms2, e.sad);
        chk("minidx2", {16'b0, mi2}, {16'b0, e.idx});
        if (e.lat >= 0) chk("latency2", 32'(edge_cnt), 32'(e.lat));
      end
    end
    pd4 = done4;
    pd2 = done2;
  end

  task automatic clr();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        frm[c][k] = '0;
        win[c][k] = '0;
      end
  endtask

  task automatic row(input int c,
                     input int a0, input int a1,
                     input int a2, input int a3,
                     input int b0, input int b1,
                     input int b2, input int b3);
    frm[c][0] = 32'(a0); frm[c][1] = 32'(a1);
    frm[c][2] = 32'(a2); frm[c][3] = 32'(a3);
    win[c][0] = 32'(b0); win[c][1] = 32'(b1);
    win[c][2] = 32'(b2); win[c][3] = 32'(b3);
  endtask

  task automatic load_basic();
    clr();
    row(0, 10, -5, 0, 100, 7, 5, 0, 90);
    row(1, 1, 2, 3, 4, 1, 2, 3, 4);
  endtask

  task automatic run(input bit two, input logic [15:0] nc,
                     input bit stall, input bit selchk,
                     input int restart_at,
                     input logic [31:0] es,
                     input logic [15:0] ei, input bit timed);
    exp_t        e;
    int          p;
    bit          pdv;
    logic        psel;
    logic [15:0] ppix;
    p = two ? 2 : 4;
    e.sad = es;
    e.idx = ei;
    e.lat = timed ? edge_cnt + 1 + int'(nc) * (2 * p + 1) : -1;
    if (two) begin
      st2 = 1'b1; nc2 = nc; q2.push_back(e);
    end else begin
      st4 = 1'b1; nc4 = nc; q4.push_back(e);
    end
    pdv = 1'b1; psel = 1'b0; ppix = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      st2 = 1'b0;
      st4 = (i == restart_at);
      if (selchk && i < 8) begin
        chk("sel_seq", {31'b0, sel4}, 32'(i % 2));
        chk("pix_seq", {16'b0, pix4}, 32'(i / 2));
      end
      if (stall) begin
        if (!pdv && busy4 && !(psel == 1'b0 && ppix == 16'd3)) begin
          chk("sel_hold", {31'b0, sel4}, {31'b0, psel});
          chk("pix_hold", {16'b0, pix4}, {16'b0, ppix});
        end
        psel = sel4;
        ppix = pix4;
        pdv  = (i % 3 == 2);
        dv4  = pdv;
      end
      if ((two ? q2.size() : q4.size()) == 0) begin
        st4 = 1'b0;
        dv4 = 1'b1;
        return;
      end
    end
    chk("search_timeout", 32'd1, 32'd0);
    st4 = 1'b0;
    dv4 = 1'b1;
  endtask

  initial begin
    exp_t e;
    bit   hit;
    rst = 1'b1;
    st4 = 1'b0; st2 = 1'b0;
    nc4 = '0;   nc2 = '0;
    dv4 = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_sel", {31'b0, sel4}, 32'd0);
    chk("rst_pix", {16'b0, pix4}, 32'd0);
    chk("rst_cand", {16'b0, cand4}, 32'd0);
    chk("rst_busy", {31'b0, busy4}, 32'd0);
    chk("rst_done", {31'b0, done4}, 32'd0);
    chk("rst_minsad", ms4, 32'hFFFF_FFFF);
    chk("rst_minidx", {16'b0, mi4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    load_basic();
    run(0, 16'd2, 0, 1, -1, 32'd0, 16'd1, 1);

    clr();
    row(0, 50, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, -20, 30, 0, 0);
    row(2, -25, 25, 0, 0, 0, 0, 0, 0);
    run(0, 16'd3, 0, 0, -1, 32'd50, 16'd0, 1);

    load_basic();
    run(0, 16'd2, 1, 0, -1, 32'd0, 16'd1, 0);

    e.sad = 32'hFFFF_FFFF; e.idx = '0; e.lat = edge_cnt + 1;
    q4.push_back(e);
    st4 = 1'b1; nc4 = 16'd0;
    @(negedge clk);
    st4 = 1'b0;
    chk("n0_busy_hi", {31'b0, busy4}, 32'd1);
    @(negedge clk);
    chk("n0_busy_lo", {31'b0, busy4}, 32'd0);
    chk("n0_done_seen", 32'(q4.size()), 32'd0);

    clr();
    frm[0][0] = 32'h7FFF_FFFF; win[0][0] = 32'h8000_0000;
    frm[0][1] = 32'h7FFF_FFFF; win[0][1] = 32'h8000_0000;
    run(1, 16'd1, 0, 0, -1, 32'hFFFF_FFFF, 16'd0, 1);

    load_basic();
    st4 = 1'b1; nc4 = 16'd2;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      st4 = 1'b0;
      hit = (cand4 == 16'd1) && sel4;
    end
    chk("reach_fetch_w1", {31'b0, hit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sel", {31'b0, sel4}, 32'd0);
    chk("abort_pix", {16'b0, pix4}, 32'd0);
    chk("abort_cand", {16'b0, cand4}, 32'd0);
    chk("abort_busy", {31'b0, busy4}, 32'd0);
    chk("abort_done", {31'b0, done4}, 32'd0);
    chk("abort_minsad", ms4, 32'hFFFF_FFFF);
    chk("abort_minidx", {16'b0, mi4}, 32'd0);
    repeat (25) @(negedge clk);

    run(0, 16'd2, 0, 0, 4, 32'd0, 16'd1, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
